compmux_scan: RTL and testbench

Scan controller for the 16:1 comparator output multiplexer. In manual mode it drives the mux select from the SPI field. In scan mode it steps the select through a channel mask. For each channel it waits for the mux and synchronizer to settle, counts high cycles of the selected comparator output over a programmable dwell window, and reports one result per channel. It sits between the SPI register bank and the mux select input, and observes the mux output in parallel with the LVDS TX path.

---
 rtl/compmux_pkg.sv | 17 +
 rtl/compmux_scan_if.sv | 30 +++
 rtl/compmux_next_ch.sv | 27 ++
 rtl/compmux_scan.sv | 148 ++++++++++++++
 tb/tb_compmux_scan.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/compmux_pkg.sv
// Shared types and default constants for the comparator mux scan controller.
package compmux_pkg;

  localparam int unsigned DEF_N_CH        = 16;
  localparam int unsigned DEF_SEL_W       = 4;
  localparam int unsigned DEF_CNT_W       = 16;
  localparam int unsigned DEF_SETTLE      = 4;
  localparam int unsigned DEF_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DWELL  = 2'd2,
    REPORT = 2'd3
  } scan_state_t;

endpackage

// File: rtl/compmux_scan_if.sv
// Control, select and result signals between the register bank and the scan controller.
interface compmux_scan_if #(
  parameter int unsigned N_CH  = 16,
  parameter int unsigned SEL_W = 4,
  parameter int unsigned CNT_W = 16
);
  logic             mode;
  logic [SEL_W-1:0] manual_sel;
  logic [N_CH-1:0]  ch_mask;
  logic [CNT_W-1:0] dwell;
  logic             start;
  logic             abort;
  logic             comp_in;
  logic [SEL_W-1:0] mux_sel;
  logic             busy;
  logic             res_valid;
  logic [SEL_W-1:0] res_ch;
  logic [CNT_W-1:0] res_count;
  logic             scan_done;

  modport master (
    output mode, manual_sel, ch_mask, dwell, start, abort, comp_in,
    input  mux_sel, busy, res_valid, res_ch, res_count, scan_done
  );

  modport slave (
    input  mode, manual_sel, ch_mask, dwell, start, abort, comp_in,
    output mux_sel, busy, res_valid, res_ch, res_count, scan_done
  );
endinterface

// File: rtl/compmux_next_ch.sv
// Priority encoder: lowest set mask bit (first) or lowest set bit above cur.
module compmux_next_ch
  import compmux_pkg::*;
#(
  parameter int unsigned N_CH  = DEF_N_CH,
  parameter int unsigned SEL_W = DEF_SEL_W
) (
  input  logic [N_CH-1:0]  mask,
  input  logic [SEL_W-1:0] cur,
  input  logic             first,
  output logic [SEL_W-1:0] nxt,
  output logic             found
);

  // Scan upward and keep the first qualifying channel.
  always_comb begin
    found = 1'b0;
    nxt   = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (!found && mask[i] && (first || (SEL_W'(i) > cur))) begin
        found = 1'b1;
        nxt   = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/compmux_scan.sv
// Scan controller: steps the comparator mux select through a channel mask,
// blanks while the mux and synchronizer settle, then counts high cycles.
module compmux_scan
  import compmux_pkg::*;
#(
  parameter int unsigned N_CH        = DEF_N_CH,
  parameter int unsigned SEL_W       = DEF_SEL_W,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned SETTLE      = DEF_SETTLE,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic           clk,
  input  logic           rst_n,
  compmux_scan_if.slave  bus
);

  // Blanking covers mux settling plus a full synchronizer flush.
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE + SYNC_STAGES - 1);

  scan_state_t      state;
  logic [SYNC_STAGES-1:0] sync;
  logic             sync_q;
  logic [N_CH-1:0]  mask_lat;
  logic [CNT_W-1:0] dwell_lat;
  logic [CNT_W-1:0] tmr;
  logic [CNT_W-1:0] cnt;
  logic [SEL_W-1:0] mux_sel;
  logic             busy;
  logic             res_valid;
  logic [SEL_W-1:0] res_ch;
  logic [CNT_W-1:0] res_count;
  logic             scan_done;

  logic [N_CH-1:0]  nc_mask;
  logic             nc_first;
  logic [SEL_W-1:0] nc_ch;
  logic             nc_found;

  assign sync_q   = sync[SYNC_STAGES-1];
  assign nc_first = (state == compmux_pkg::IDLE);
  assign nc_mask  = nc_first ? bus.ch_mask : mask_lat;

  compmux_next_ch #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_next_ch (
    .mask  (nc_mask),
    .cur   (mux_sel),
    .first (nc_first),
    .nxt   (nc_ch),
    .found (nc_found)
  );

  // Bring the asynchronous mux output into the clk domain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], bus.comp_in};
    end
  end

  // Scan FSM with registered select, status and result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= compmux_pkg::IDLE;
      mask_lat  <= '0;
      dwell_lat <= CNT_W'(1);
      tmr       <= '0;
      cnt       <= '0;
      mux_sel   <= '0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_ch    <= '0;
      res_count <= '0;
      scan_done <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      scan_done <= 1'b0;
      if (state == compmux_pkg::IDLE) begin
        if (!bus.mode) begin
          mux_sel <= bus.manual_sel;
        end else if (bus.start) begin
          mask_lat  <= bus.ch_mask;
          dwell_lat <= (bus.dwell == '0) ? CNT_W'(1) : bus.dwell;
          if (nc_found) begin
            mux_sel <= nc_ch;
            state   <= compmux_pkg::SETTLE;
            busy    <= 1'b1;
            tmr     <= '0;
          end else begin
            scan_done <= 1'b1;
          end
        end
      end else if (bus.abort || !bus.mode) begin
        // Cancel wins over any transition, including the result strobe.
        state <= compmux_pkg::IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          compmux_pkg::SETTLE: begin
            if (tmr == SETTLE_LAST) begin
              state <= compmux_pkg::DWELL;
              tmr   <= '0;
              cnt   <= '0;
            end else begin
              tmr <= tmr + CNT_W'(1);
            end
          end
          compmux_pkg::DWELL: begin
            cnt <= cnt + CNT_W'(sync_q);
            if (tmr == dwell_lat - CNT_W'(1)) begin
              state     <= compmux_pkg::REPORT;
              res_valid <= 1'b1;
              res_ch    <= mux_sel;
              res_count <= cnt + CNT_W'(sync_q);
              scan_done <= !nc_found;
            end else begin
              tmr <= tmr + CNT_W'(1);
            end
          end
          compmux_pkg::REPORT: begin
            if (nc_found) begin
              mux_sel <= nc_ch;
              state   <= compmux_pkg::SETTLE;
              tmr     <= '0;
            end else begin
              state <= compmux_pkg::IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= compmux_pkg::IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.mux_sel   = mux_sel;
  assign bus.busy      = busy;
  assign bus.res_valid = res_valid;
  assign bus.res_ch    = res_ch;
  assign bus.res_count = res_count;
  assign bus.scan_done = scan_done;

endmodule

// File: tb/tb_compmux_scan.sv
// Directed bench for compmux_scan with a scoreboard of expected result/done events.
module tb_compmux_scan;

  logic clk = 1'b0;
  logic rst_n;
  logic tog = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   t0;

  typedef struct {
    logic        empty;
    logic [3:0]  ch;
    logic [15:0] cnt;
    int          cyc;
    logic        done;
  } exp_t;

  exp_t sb[$];

  compmux_scan_if #(.N_CH(16), .SEL_W(4), .CNT_W(16)) bus ();

  compmux_scan dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Toggle comp_in once per cycle when enabled.
  always @(posedge clk) begin
    if (tog) begin
      #1;
      bus.comp_in = ~bus.comp_in;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic empty, input logic [3:0] ch, input logic [15:0] cnt,
                      input int c, input logic done);
    exp_t e;
    e.empty = empty;
    e.ch    = ch;
    e.cnt   = cnt;
    e.cyc   = c;
    e.done  = done;
    sb.push_back(e);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, sb.size(), 0);
    tick(2);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mux_sel"},   bus.mux_sel,   0);
    chk({tag, "_busy"},      bus.busy,      0);
    chk({tag, "_res_valid"}, bus.res_valid, 0);
    chk({tag, "_res_ch"},    bus.res_ch,    0);
    chk({tag, "_res_count"}, bus.res_count, 0);
    chk({tag, "_scan_done"}, bus.scan_done, 0);
  endtask

  // Pop and compare an expected event whenever the DUT strobes.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (bus.res_valid === 1'b1 || bus.scan_done === 1'b1) begin
      chk("event_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("event_cycle", cyc, e.cyc);
        chk("res_valid", bus.res_valid, !e.empty);
        chk("scan_done", bus.scan_done, e.done);
        if (!e.empty) begin
          chk("res_ch", bus.res_ch, e.ch);
          chk("res_count", bus.res_count, e.cnt);
        end
      end
    end
  end

  initial begin
    rst_n          = 1'b0;
    bus.mode       = 1'b0;
    bus.manual_sel = '0;
    bus.ch_mask    = '0;
    bus.dwell      = '0;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.comp_in    = 1'b0;
    tick(2);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Manual mode: one-cycle select latency, start ignored.
    bus.manual_sel = 4'hA;
    tick();
    chk("manual_sel", bus.mux_sel, 4'hA);
    pulse_start();
    chk("manual_busy0", bus.busy, 0);
    tick();
    chk("manual_busy1", bus.busy, 0);
    chk("manual_hold", bus.mux_sel, 4'hA);

    // Two-channel scan with comp_in held high.
    bus.mode    = 1'b1;
    bus.comp_in = 1'b1;
    bus.ch_mask = 16'h8001;
    bus.dwell   = 16'd10;
    tick();
    t0 = cyc;
    push(1'b0, 4'd0,  16'd10, t0 + 17, 1'b0);
    push(1'b0, 4'd15, 16'd10, t0 + 34, 1'b1);
    pulse_start();
    chk("scan_busy_c1", bus.busy, 1);
    chk("scan_sel_c1", bus.mux_sel, 0);
    tick(33);
    chk("scan_busy_c34", bus.busy, 1);
    tick();
    chk("scan_busy_c35", bus.busy, 0);
    chk("scan_sel_hold", bus.mux_sel, 15);
    chk("res_ch_hold", bus.res_ch, 15);
    chk("res_count_hold", bus.res_count, 10);
    chk("scan_sb_empty", sb.size(), 0);

    // Toggling input counts half the window; then held low counts zero.
    bus.ch_mask = 16'h0010;
    bus.dwell   = 16'd100;
    tog = 1'b1;
    t0 = cyc;
    push(1'b0, 4'd4, 16'd50, t0 + 107, 1'b1);
    pulse_start();
    drain("toggle_drain", 200);
    tog = 1'b0;
    tick();
    bus.comp_in = 1'b0;
    t0 = cyc;
    push(1'b0, 4'd4, 16'd0, t0 + 107, 1'b1);
    pulse_start();
    drain("low_drain", 200);

    // Empty mask: done only, busy never rises.
    bus.ch_mask = 16'h0000;
    t0 = cyc;
    push(1'b1, 4'd0, 16'd0, t0 + 1, 1'b1);
    pulse_start();
    chk("empty_busy", bus.busy, 0);
    drain("empty_drain", 10);

    // Zero dwell acts as a one-cycle window.
    bus.comp_in = 1'b1;
    bus.ch_mask = 16'h0002;
    bus.dwell   = 16'd0;
    t0 = cyc;
    push(1'b0, 4'd1, 16'd1, t0 + 8, 1'b1);
    pulse_start();
    drain("dwell0_drain", 30);

    // Abort in the first channel's dwell: nothing reported.
    bus.ch_mask = 16'h0007;
    bus.dwell   = 16'd5;
    pulse_start();
    tick(8);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_busy", bus.busy, 0);
    tick(20);
    chk("abort_no_events", sb.size(), 0);

    // Immediate restart runs all three channels.
    t0 = cyc;
    push(1'b0, 4'd0, 16'd5, t0 + 12, 1'b0);
    push(1'b0, 4'd1, 16'd5, t0 + 24, 1'b0);
    push(1'b0, 4'd2, 16'd5, t0 + 36, 1'b1);
    pulse_start();
    drain("restart_drain", 60);

    // Synchronous reset mid-settle clears everything.
    bus.ch_mask = 16'h0003;
    pulse_start();
    tick(2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_reset_outputs("midreset");
    tick(30);
    chk("midreset_no_events", sb.size(), 0);

    // Mask and dwell changes after start do not affect the running scan.
    bus.ch_mask = 16'h0005;
    bus.dwell   = 16'd3;
    t0 = cyc;
    push(1'b0, 4'd0, 16'd3, t0 + 10, 1'b0);
    push(1'b0, 4'd2, 16'd3, t0 + 20, 1'b1);
    pulse_start();
    bus.ch_mask = 16'hFFFF;
    bus.dwell   = 16'd50;
    drain("latch_drain", 60);
    chk("latch_busy_end", bus.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
